alu_cmd_ctrl: RTL and testbench

ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/alu_cmd_ctrl.sv | 171 +++++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU command controller slice:
//   - alu_op_e   : ALU operation select codes (AND=0 .. SHL=7)
//   - FLAG_*     : bit positions of the flags inside the packed {N, V, C, Z} nibble
//   - alu_cmd_t  : packed command word (operands + op), tag is carried alongside
//   - pack_flags : builds the {N, V, C, Z} nibble from the ALU's individual flag bits
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_XOR = 3'd2,
    ALU_ADD = 3'd3,
    ALU_SUB = 3'd4,
    ALU_NOR = 3'd5,
    ALU_SHR = 3'd6,
    ALU_SHL = 3'd7
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  // The tag width is a per-instance parameter, so it is not part of this struct;
  // the controller appends it below the struct when storing a command.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    alu_op_e    op;
  } alu_cmd_t;

  function automatic logic [3:0] pack_flags(input logic n, input logic v,
                                            input logic c, input logic z);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO used for both the command and the response queue.
//   Pointers carry one extra bit so that full (count == DEPTH) and empty
//   (count == 0) are distinguishable; the occupancy is their difference.
//   Pushes while full and pops while empty are ignored.
// Ports
//   clk, reset      : clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data : write request and data
//   pop             : remove the head entry
//   pop_data        : current head entry (meaningful only when count != 0)
//   count           : number of stored entries, 0..DEPTH
module sync_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_CNT = (AW+1)'(0);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      count_s;
  logic             wr_en_s;
  logic             rd_en_s;

  assign count_s  = wr_ptr_r - rd_ptr_r;
  assign wr_en_s  = push && (count_s != FULL_CNT);
  assign rd_en_s  = pop && (count_s != ZERO_CNT);
  assign count    = count_s;
  assign pop_data = mem_r[rd_ptr_r[AW-1:0]];

  // Read/write pointers; they wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= ZERO_CNT;
      rd_ptr_r <= ZERO_CNT;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_CNT;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_CNT;
      end
    end
  end

  // Storage array; contents need no reset because reads are qualified by count.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl
//   Queues ALU commands, issues them one per cycle to an external ALU with
//   registered outputs, and queues the results (with their tags) for a
//   consumer. A credit check (response occupancy + in-flight op < DEPTH)
//   guarantees that every issued op has a response slot, so a stalled
//   consumer can never cause a result to be lost.
//   Handshake-to-response latency is 3 cycles with no stalls:
//   issue -> ALU register -> response FIFO write -> rsp_valid.
// Ports
//   clk, reset                        : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready               : command handshake
//   cmd_a, cmd_b, cmd_op, cmd_tag     : command payload
//   alu_a, alu_b, alu_sel             : ALU inputs, zero when not issuing
//   alu_result, alu_zero/carry/
//     overflow/negative               : ALU registered outputs
//   rsp_valid/rsp_ready               : response handshake
//   rsp_result, rsp_flags {N,V,C,Z},
//     rsp_tag                         : response payload, zero when empty
//   done_cnt                          : responses delivered, wraps at 8 bits
module alu_cmd_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [7:0]       alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_negative,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [7:0]       done_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CMD_W = $bits(alu_cmd_t) + TAG_W;
  localparam int RSP_W = 8 + 4 + TAG_W;
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ZERO_CNT   = (AW+1)'(0);
  localparam logic [AW+1:0] CREDIT_LIM = (AW+2)'(DEPTH);

  logic [AW:0]        cmd_count_s;
  logic [AW:0]        rsp_count_s;
  logic               cmd_push_s;
  alu_cmd_t           cmd_push_fields_s;
  logic [CMD_W-1:0]   cmd_push_data_s;
  logic [CMD_W-1:0]   cmd_head_s;
  alu_cmd_t           cmd_head_fields_s;
  logic [TAG_W-1:0]   cmd_head_tag_s;
  logic [AW+1:0]      credit_use_s;
  logic               credit_s;
  logic               issue_s;
  logic [RSP_W-1:0]   rsp_push_data_s;
  logic [RSP_W-1:0]   rsp_head_s;
  logic               rsp_pop_s;
  logic               in_flight_r;
  logic [TAG_W-1:0]   tag_q_r;
  logic [7:0]         done_cnt_r;

  // Command side: ready only when not full, even if the head pops this cycle.
  assign cmd_ready  = (cmd_count_s != FULL_CNT);
  assign cmd_push_s = cmd_valid && cmd_ready;

  // Pack the incoming command as {struct, tag}.
  always_comb begin
    cmd_push_fields_s.a  = cmd_a;
    cmd_push_fields_s.b  = cmd_b;
    cmd_push_fields_s.op = alu_op_e'(cmd_op);
    cmd_push_data_s      = {cmd_push_fields_s, cmd_tag};
  end

  assign {cmd_head_fields_s, cmd_head_tag_s} = cmd_head_s;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_push_s),
    .push_data (cmd_push_data_s),
    .pop       (issue_s),
    .pop_data  (cmd_head_s),
    .count     (cmd_count_s)
  );

  // The in-flight op already owns a response slot, so it counts against credit.
  assign credit_use_s = {1'b0, rsp_count_s} + {{(AW+1){1'b0}}, in_flight_r};
  assign credit_s     = (credit_use_s < CREDIT_LIM);
  assign issue_s      = (cmd_count_s != ZERO_CNT) && credit_s;

  // ALU inputs follow the FIFO head while issuing and are held at zero otherwise.
  always_comb begin
    if (issue_s) begin
      alu_a   = cmd_head_fields_s.a;
      alu_b   = cmd_head_fields_s.b;
      alu_sel = cmd_head_fields_s.op;
    end else begin
      alu_a   = 8'h00;
      alu_b   = 8'h00;
      alu_sel = 3'd0;
    end
  end

  // The ALU result of last cycle's issue is written the cycle after issue.
  assign rsp_push_data_s = {alu_result,
                            pack_flags(alu_negative, alu_overflow, alu_carry, alu_zero),
                            tag_q_r};

  sync_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_flight_r),
    .push_data (rsp_push_data_s),
    .pop       (rsp_pop_s),
    .pop_data  (rsp_head_s),
    .count     (rsp_count_s)
  );

  assign rsp_valid = (rsp_count_s != ZERO_CNT);
  assign rsp_pop_s = rsp_valid && rsp_ready;

  // Response payload is forced to zero when empty so stale storage never shows.
  always_comb begin
    if (rsp_valid) begin
      {rsp_result, rsp_flags, rsp_tag} = rsp_head_s;
    end else begin
      rsp_result = 8'h00;
      rsp_flags  = 4'b0000;
      rsp_tag    = {TAG_W{1'b0}};
    end
  end

  // Issue tracking (in-flight bit and its tag) and the delivered-response counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_flight_r <= 1'b0;
      tag_q_r     <= {TAG_W{1'b0}};
      done_cnt_r  <= 8'h00;
    end else begin
      in_flight_r <= issue_s;
      if (issue_s) begin
        tag_q_r <= cmd_head_tag_s;
      end
      if (rsp_pop_s) begin
        done_cnt_r <= done_cnt_r + 8'd1;
      end
    end
  end

  assign done_cnt = done_cnt_r;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl
//   Bench for alu_cmd_ctrl. Contains a registered reference ALU that shares the
//   controller's reset, a scoreboard queue filled on each command handshake and
//   drained on each response handshake, and a linear directed sequence.
module tb_alu_cmd_ctrl;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int EXP_W = 8 + 4 + TAG_W;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [2:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [2:0]       alu_sel;
  logic [7:0]       alu_result;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_overflow;
  logic             alu_negative;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_result;
  logic [3:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic [7:0]       done_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [EXP_W-1:0] sb[$];

  int acc, idx, first_v, nvalid, gaps;
  bit hs;

  alu_cmd_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_op       (cmd_op),
    .cmd_tag      (cmd_tag),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .alu_negative (alu_negative),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .rsp_tag      (rsp_tag),
    .done_cnt     (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {result, N, V, C, Z}.
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
    logic [8:0] w;
    logic [7:0] r;
    logic c, v;
    w = 9'd0; r = 8'd0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: begin
        w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd4: begin
        w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = ~w[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd5: r = ~(a | b);
      3'd6: begin r = {1'b0, a[7:1]}; c = a[0]; end
      3'd7: begin r = {a[6:0], 1'b0}; c = a[7]; end
      default: r = 8'd0;
    endcase
    return {r, r[7], v, c, (r == 8'd0)};
  endfunction

  // External ALU with registered outputs, reset together with the controller.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {alu_result, alu_negative, alu_overflow, alu_carry, alu_zero} <= 12'd0;
    end else begin
      {alu_result, alu_negative, alu_overflow, alu_carry, alu_zero} <= alu_ref(alu_a, alu_b, alu_sel);
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", name, obs, exp);
    end
  endtask

  // Scoreboard: push on the handshake about to happen, compare on each response pop.
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_valid && cmd_ready) begin
        sb.push_back({alu_ref(cmd_a, cmd_b, cmd_op), cmd_tag});
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(sb.size()), 32'd1);
        end else begin
          check("rsp_scoreboard", 32'({rsp_result, rsp_flags, rsp_tag}), 32'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int i);
    cmd_a   = 8'($urandom);
    cmd_b   = 8'($urandom);
    cmd_op  = 3'(i);
    cmd_tag = TAG_W'(i);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    sb.delete();
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Offer one command and return just after its handshake edge.
  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input logic [TAG_W-1:0] tag);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    check("cmd_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input logic [7:0] r, input logic [3:0] f);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({name, "_result"}, 32'(rsp_result), 32'(r));
      check({name, "_flags"}, 32'(rsp_flags), 32'(f));
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_a = 8'd0; cmd_b = 8'd0;
    cmd_op = 3'd0; cmd_tag = {TAG_W{1'b0}}; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check("rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);

    // ADD 0x7F + 0x01, tag 3, with cycle-exact latency
    send_cmd(8'h7F, 8'h01, 3'd3, 4'd3);
    @(negedge clk);
    check("add_issue_alu", 32'({alu_a, alu_b, alu_sel}), 32'({8'h7F, 8'h01, 3'd3}));
    check("add_lat1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("add_idle_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    check("add_lat2_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("add_lat3_valid", 32'(rsp_valid), 32'd1);
    check("add_result", 32'(rsp_result), 32'h80);
    check("add_flags", 32'(rsp_flags), 32'b1100);
    check("add_tag", 32'(rsp_tag), 32'd3);

    // SUB and AND
    send_cmd(8'h05, 8'h03, 3'd4, 4'd1);
    wait_rsp("sub", 8'h02, 4'b0010);
    send_cmd(8'hF0, 8'h0F, 3'd0, 4'd2);
    wait_rsp("and", 8'h00, 4'b0001);

    // Backpressure: 12 offered, 2*DEPTH accepted
    do_reset();
    rsp_ready = 1'b0;
    acc = 0; idx = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; drive(idx);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      hs = cmd_ready;
      @(posedge clk); #1;
      if (hs) begin
        acc++; idx++;
        if (idx < 12) drive(idx);
        else cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_accepted", 32'(acc), 32'(2 * DEPTH));
    check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    check("bp_done_hold", 32'(done_cnt), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_cnt == 8'd8) break;
    end
    repeat (3) @(negedge clk);
    check("bp_done_cnt", 32'(done_cnt), 32'd8);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Back-to-back stream of 20 commands
    do_reset();
    first_v = -1; nvalid = 0; gaps = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (c < 20) begin cmd_valid = 1'b1; drive(c); end
      else cmd_valid = 1'b0;
      @(negedge clk);
      if (c < 20) check("stream_cmd_ready", 32'(cmd_ready), 32'd1);
      if (rsp_valid) begin
        if (first_v < 0) first_v = c;
        nvalid++;
      end else if (first_v >= 0 && nvalid < 20) begin
        gaps++;
      end
    end
    check("stream_first", 32'(first_v), 32'd3);
    check("stream_count", 32'(nvalid), 32'd20);
    check("stream_gaps", 32'(gaps), 32'd0);
    check("stream_done_cnt", 32'(done_cnt), 32'd20);
    check("stream_sb_empty", 32'(sb.size()), 32'd0);

    // Reset with responses queued and one op in flight
    do_reset();
    rsp_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1; drive(c);
      @(negedge clk);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_queued", 32'(rsp_valid), 32'd1);
    do_reset();
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("mid_no_stale", 32'(rsp_valid), 32'd0);
    end
    send_cmd(8'h12, 8'h34, 3'd3, 4'd5);
    wait_rsp("mid_next", 8'h46, 4'b0000);
    @(negedge clk);
    check("mid_done_cnt", 32'(done_cnt), 32'd1);

    // Random consumer backpressure, 40 commands
    do_reset();
    idx = 0; hs = 1'b0;
    drive(idx);
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (hs) begin
        idx++;
        if (idx < 40) drive(idx);
      end
      cmd_valid = (idx < 40);
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      hs = cmd_valid && cmd_ready;
      if (idx >= 40 && done_cnt == 8'd40) break;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rand_sent", 32'(idx), 32'd40);
    check("rand_done_cnt", 32'(done_cnt), 32'd40);
    check("rand_sb_empty", 32'(sb.size()), 32'd0);
    check("rand_rsp_idle", 32'(rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
